// File: rtl/sodor_imem_pkg.sv
// sodor_imem_pkg: shared types, parameter bounds and the fetch address check for the imem responder
package sodor_imem_pkg;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;
    localparam int RESP_DEPTH_MIN = 1;
    localparam int RESP_DEPTH_MAX = 4;
    localparam int RESP_DATA_W = 32;

    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        logic err;
    } imem_resp_t;

    typedef struct packed {
        logic [31:0] idx;
        logic err;
    } addr_chk_t;

    // Offset wraps modulo 2^addr_w, so addresses below the base land far out of range.
    function automatic addr_chk_t addr_check(input logic [63:0] addr, input logic [63:0] base,
                                             input int addr_w, input int depth_words);
        logic [63:0] mask;
        logic [63:0] off;
        mask = (addr_w >= 64) ? '1 : (64'd1 << addr_w) - 64'd1;
        off = (addr - base) & mask;
        addr_check.err = (addr[1:0] != 2'b00) || (off >= (64'($unsigned(depth_words)) << 2));
        addr_check.idx = 32'(off >> 2);
    endfunction
endpackage

// File: rtl/sodor_imem_resp_fifo.sv
// sodor_imem_resp_fifo: small response FIFO that presents its input directly while empty
module sodor_imem_resp_fifo
    import sodor_imem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_in_valid,
    input  imem_resp_t                 i_in_data,
    input  logic                       i_out_ready,
    output logic                       o_out_valid,
    output imem_resp_t                 o_out_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    imem_resp_t r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic w_wr;
    logic w_rd;

    always_comb begin
        o_empty = r_count == '0;
        o_full = r_count == CW'(DEPTH);
        o_count = r_count;
        o_out_valid = !o_empty || i_in_valid;
        o_out_data = o_empty ? i_in_data : r_mem[r_rp];
        w_rd = !o_empty && i_out_ready;
        w_wr = i_in_valid && !(o_empty && i_out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= i_in_data;
                r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            end
            if (w_rd)
                r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end
endmodule

// File: rtl/sodor_imem_responder.sv
// sodor_imem_responder: credit-limited imem slave with latency pipeline, text RAM and preload port
module sodor_imem_responder
    import sodor_imem_pkg::*;
#(
    parameter int               ADDR_W      = 32,
    parameter int               DATA_W      = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
    parameter int               LATENCY     = 1,
    parameter int               RESP_DEPTH  = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           io_imem_req_valid,
    output logic                           io_imem_req_ready,
    input  logic [ADDR_W-1:0]              io_imem_req_bits_addr,
    output logic                           io_imem_resp_valid,
    input  logic                           io_imem_resp_ready,
    output logic [DATA_W-1:0]              io_imem_resp_bits_data,
    output logic                           io_imem_resp_bits_err,
    input  logic                           io_load_valid,
    input  logic [$clog2(DEPTH_WORDS)-1:0] io_load_idx,
    input  logic [DATA_W-1:0]              io_load_data
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0] r_pv;
    imem_resp_t r_pipe [LATENCY];
    logic [CNT_W-1:0] r_outst;
    addr_chk_t w_chk;
    logic [IDX_W-1:0] w_idx;
    logic w_acc;
    logic w_consume;
    logic w_out_valid;
    imem_resp_t w_out;
    logic [CNT_W-1:0] w_count;
    logic w_full;
    logic w_empty;

    // A consume in the same cycle frees the credit the new request needs.
    always_comb begin
        w_chk = addr_check(64'(io_imem_req_bits_addr), 64'(BASE_ADDR), ADDR_W, DEPTH_WORDS);
        w_idx = IDX_W'(w_chk.idx);
        io_imem_resp_valid = w_out_valid && !reset;
        io_imem_resp_bits_data = reset ? '0 : DATA_W'(w_out.data);
        io_imem_resp_bits_err = w_out.err && !reset;
        w_consume = io_imem_resp_valid && io_imem_resp_ready;
        io_imem_req_ready = !reset && (r_outst < CNT_W'(RESP_DEPTH) ||
                            (r_outst == CNT_W'(RESP_DEPTH) && w_consume));
        w_acc = io_imem_req_valid && io_imem_req_ready;
    end

    always_ff @(posedge clock)
        if (io_load_valid)
            r_mem[io_load_idx] <= io_load_data;

    // Stage 0 reads the RAM; a same-edge preload write is not yet visible, giving read-before-write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pv <= '0;
            for (int i = 0; i < LATENCY; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pv[0] <= w_acc;
            r_pipe[0] <= '{data: (w_acc && !w_chk.err) ? RESP_DATA_W'(r_mem[w_idx]) : '0,
                           err: w_acc && w_chk.err};
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_outst <= '0;
        else
            r_outst <= r_outst + CNT_W'(w_acc) - CNT_W'(w_consume);
    end

    sodor_imem_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .i_in_valid (r_pv[LATENCY-1]),
        .i_in_data  (r_pipe[LATENCY-1]),
        .i_out_ready(io_imem_resp_ready),
        .o_out_valid(w_out_valid),
        .o_out_data (w_out),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clock) begin
        assert (LATENCY >= LATENCY_MIN && LATENCY <= LATENCY_MAX && RESP_DEPTH >= RESP_DEPTH_MIN &&
                RESP_DEPTH <= RESP_DEPTH_MAX && DATA_W == RESP_DATA_W)
            else $error("sodor_imem_responder: illegal parameters");
        if (!reset) begin
            assert (!(r_pv[LATENCY-1] && w_full)) else $error("response buffer written while full");
            assert (w_empty ? w_count == '0 : w_count <= r_outst)
                else $error("response buffer holds more than outstanding");
        end
    end
endmodule

// File: tb/tb_sodor_imem_responder.sv
// tb_sodor_imem_responder: scoreboard bench for LATENCY=1 and LATENCY=3 responders sharing stimulus
module tb_sodor_imem_responder;
    typedef struct packed {
        logic err;
        logic [31:0] data;
    } exp_t;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v1 = 1'b0;
    logic v3 = 1'b0;
    logic [31:0] addr = '0;
    logic rr = 1'b0;
    logic lv = 1'b0;
    logic [9:0] li = '0;
    logic [31:0] ld = '0;
    logic rdy1, rv1, err1, rdy3, rv3, err3;
    logic [31:0] dat1, dat3;

    logic [31:0] mdl [1024];
    exp_t sb1[$];
    exp_t sb3[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;
    logic acc1, acc3, fire1, fire3;

    always #5 clk = ~clk;

    sodor_imem_responder #(.LATENCY(1), .RESP_DEPTH(2)) u1 (
        .clock(clk), .reset(rst),
        .io_imem_req_valid(v1), .io_imem_req_ready(rdy1), .io_imem_req_bits_addr(addr),
        .io_imem_resp_valid(rv1), .io_imem_resp_ready(rr),
        .io_imem_resp_bits_data(dat1), .io_imem_resp_bits_err(err1),
        .io_load_valid(lv), .io_load_idx(li), .io_load_data(ld)
    );

    sodor_imem_responder #(.LATENCY(3), .RESP_DEPTH(2)) u3 (
        .clock(clk), .reset(rst),
        .io_imem_req_valid(v3), .io_imem_req_ready(rdy3), .io_imem_req_bits_addr(addr),
        .io_imem_resp_valid(rv3), .io_imem_resp_ready(rr),
        .io_imem_resp_bits_data(dat3), .io_imem_resp_bits_err(err3),
        .io_load_valid(lv), .io_load_idx(li), .io_load_data(ld)
    );

    function automatic exp_t exp_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        exp_of.err = (a[1:0] != 2'b00) || (off >= 32'd4096);
        exp_of.data = exp_of.err ? 32'h0 : mdl[off[11:2]];
    endfunction

    // One bus cycle: drive at negedge, observe at negedge+1, push expectations on accept.
    task automatic cyc(input logic r, input logic a_v1, input logic a_v3, input logic [31:0] a,
                       input logic rdy_in, input logic l_v, input logic [9:0] l_i, input logic [31:0] l_d);
        exp_t e;
        @(negedge clk);
        rst = r; v1 = a_v1; v3 = a_v3; addr = a; rr = rdy_in; lv = l_v; li = l_i; ld = l_d;
        #1;
        e = exp_of(a);
        acc1 = v1 && rdy1;
        acc3 = v3 && rdy3;
        fire1 = rv1 && rr;
        fire3 = rv3 && rr;
        if (acc1) sb1.push_back(e);
        if (acc3) sb3.push_back(e);
        if (l_v) mdl[l_i] = l_d;
        n_cyc++;
    endtask

    task automatic test_reset;
        logic [31:0] img [6];
        img = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'hFFDF_F06F, 32'h0, 32'h0000_0013};
        for (int i = 0; i < 6; i++)
            if (i != 4) cyc(1, 1, 1, BASE, 1, 1, 10'(i), img[i]);
        n_cmp++;
        if (rdy1 !== 1'b0 || rdy3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_req_ready got %b/%b want 0/0", rdy1, rdy3);
        end
        n_cmp++;
        if ({rv1, err1, dat1} !== 34'h0) begin
            n_bad++; $display("FAIL reset_resp got valid=%b err=%b data=%h want 0/0/0", rv1, err1, dat1);
        end
        cyc(0, 0, 0, BASE, 1, 0, 0, 0);
        n_cmp++;
        if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_ready got %b/%b want 1/1", rdy1, rdy3);
        end
        n_cmp++;
        if ({rv1, err1, dat1} !== 34'h0) begin
            n_bad++; $display("FAIL post_reset_resp got valid=%b err=%b data=%h want 0/0/0", rv1, err1, dat1);
        end
    endtask

    task automatic test_back_to_back;
        int acq[$];
        int t;
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            cyc(0, k < 4, 0, BASE + 32'(4 * k), 1, 0, 0, 0);
            if (k < 4) begin
                n_cmp++;
                if (acc1 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept%0d got %b want 1", k, acc1); end
            end
            if (acc1) acq.push_back(n_cyc);
            if (fire1) begin
                n_cmp++;
                if (sb1.size() == 0 || acq.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra got data=%h want no response", dat1);
                end else begin
                    e = sb1.pop_front();
                    t = acq.pop_front();
                    if ({err1, dat1} !== {e.err, e.data}) begin
                        n_bad++; $display("FAIL b2b_data got err=%b data=%h want err=%b data=%h", err1, dat1, e.err, e.data);
                    end
                    n_cmp++;
                    if (n_cyc - t !== 1) begin
                        n_bad++; $display("FAIL b2b_latency got %0d want 1", n_cyc - t);
                    end
                end
            end
        end
        n_cmp++;
        if (sb1.size() !== 0) begin n_bad++; $display("FAIL b2b_drain got %0d pending want 0", sb1.size()); end
    endtask

    task automatic test_backpressure;
        int j = 0;
        logic r;
        exp_t e;
        for (int k = 0; k < 14; k++) begin
            r = (k == 5) || (k >= 8);
            cyc(0, j < 3, 0, BASE + 32'(4 * j), r, 0, 0, 0);
            if (acc1) j++;
            if (k >= 2 && k <= 4) begin
                n_cmp++;
                if ({rdy1, rv1, dat1} !== {1'b0, 1'b1, 32'h0000_0013}) begin
                    n_bad++; $display("FAIL bp_hold%0d got ready=%b valid=%b data=%h want 0/1/00000013", k, rdy1, rv1, dat1);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if ({fire1, acc1} !== 2'b11) begin
                    n_bad++; $display("FAIL bp_swap got consume=%b accept=%b want 1/1", fire1, acc1);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if ({rdy1, dat1} !== {1'b0, 32'h0010_0093}) begin
                    n_bad++; $display("FAIL bp_next got ready=%b data=%h want 0/00100093", rdy1, dat1);
                end
            end
            if (fire1) begin
                n_cmp++;
                if (sb1.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra got data=%h want no response", dat1);
                end else begin
                    e = sb1.pop_front();
                    if ({err1, dat1} !== {e.err, e.data}) begin
                        n_bad++; $display("FAIL bp_data got err=%b data=%h want err=%b data=%h", err1, dat1, e.err, e.data);
                    end
                end
            end
        end
        n_cmp++;
        if (sb1.size() !== 0 || j !== 3) begin
            n_bad++; $display("FAIL bp_drain got pending=%0d accepted=%0d want 0/3", sb1.size(), j);
        end
    endtask

    task automatic test_err;
        logic [31:0] al [4];
        int r = 0;
        exp_t e;
        al = '{32'h8000_0002, 32'h8000_1000, 32'hFFFF_FFFC, 32'h8000_0004};
        for (int k = 0; k < 10; k++) begin
            cyc(0, k < 4, 0, al[k < 4 ? k : 0], 1, 0, 0, 0);
            if (fire1) begin
                n_cmp++;
                if (sb1.size() == 0) begin
                    n_bad++; $display("FAIL err_extra got data=%h want no response", dat1);
                end else begin
                    e = sb1.pop_front();
                    if ({err1, dat1} !== {e.err, e.data}) begin
                        n_bad++; $display("FAIL err_data%0d got err=%b data=%h want err=%b data=%h", r, err1, dat1, e.err, e.data);
                    end
                end
                n_cmp++;
                if ({err1, dat1} !== ((r < 3) ? {1'b1, 32'h0} : {1'b0, 32'h0010_0093})) begin
                    n_bad++; $display("FAIL err_const%0d got err=%b data=%h", r, err1, dat1);
                end
                r++;
            end
        end
        n_cmp++;
        if (r !== 4) begin n_bad++; $display("FAIL err_count got %0d want 4", r); end
    endtask

    task automatic test_rbw;
        int r = 0;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            cyc(0, k < 2, 0, 32'h8000_0014, 1, k == 0, 10'd5, 32'hDEAD_BEEF);
            if (fire1) begin
                n_cmp++;
                if (sb1.size() == 0) begin
                    n_bad++; $display("FAIL rbw_extra got data=%h want no response", dat1);
                end else begin
                    e = sb1.pop_front();
                    if ({err1, dat1} !== {e.err, e.data} || dat1 !== ((r == 0) ? 32'h0000_0013 : 32'hDEAD_BEEF)) begin
                        n_bad++; $display("FAIL rbw_data%0d got err=%b data=%h want err=%b data=%h", r, err1, dat1, e.err, e.data);
                    end
                end
                r++;
            end
        end
        n_cmp++;
        if (r !== 2) begin n_bad++; $display("FAIL rbw_count got %0d want 2", r); end
    endtask

    task automatic test_latency3;
        int t;
        logic seen = 1'b0;
        exp_t e;
        cyc(0, 0, 1, 32'h8000_0008, 1, 0, 0, 0);
        t = n_cyc;
        n_cmp++;
        if (acc3 !== 1'b1) begin n_bad++; $display("FAIL lat3_accept got %b want 1", acc3); end
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, BASE, 1, 0, 0, 0);
            if (rv3 && !seen) begin
                seen = 1'b1;
                n_cmp++;
                if (n_cyc - t !== 3) begin n_bad++; $display("FAIL lat3_latency got %0d want 3", n_cyc - t); end
            end
            if (fire3) begin
                n_cmp++;
                if (sb3.size() == 0) begin
                    n_bad++; $display("FAIL lat3_extra got data=%h want no response", dat3);
                end else begin
                    e = sb3.pop_front();
                    if ({err3, dat3} !== {e.err, e.data} || dat3 !== 32'h0020_0113) begin
                        n_bad++; $display("FAIL lat3_data got err=%b data=%h want err=%b data=%h", err3, dat3, e.err, e.data);
                    end
                end
            end
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL lat3_timeout got no response want one"); end
    endtask

    task automatic test_reset_flush;
        int leaks = 0;
        int r = 0;
        exp_t e;
        cyc(0, 0, 1, 32'h8000_0004, 1, 0, 0, 0);
        n_cmp++;
        if (acc3 !== 1'b1) begin n_bad++; $display("FAIL flush_accept0 got %b want 1", acc3); end
        cyc(0, 0, 1, 32'h8000_0014, 1, 0, 0, 0);
        n_cmp++;
        if (acc3 !== 1'b1) begin n_bad++; $display("FAIL flush_accept1 got %b want 1", acc3); end
        cyc(1, 0, 0, BASE, 1, 0, 0, 0);
        sb1.delete();
        sb3.delete();
        n_cmp++;
        if ({rv3, rdy3} !== 2'b00) begin n_bad++; $display("FAIL flush_in_reset got valid=%b ready=%b want 0/0", rv3, rdy3); end
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, BASE, 1, 0, 0, 0);
            if (k == 0) begin
                n_cmp++;
                if (rdy3 !== 1'b1) begin n_bad++; $display("FAIL flush_ready got %b want 1", rdy3); end
            end
            if (rv3) leaks++;
        end
        n_cmp++;
        if (leaks !== 0) begin n_bad++; $display("FAIL flush_leak got %0d responses want 0", leaks); end
        cyc(0, 0, 1, 32'h8000_0004, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h8000_0014, 0, 0, 0, 0);
        n_cmp++;
        if (sb3.size() !== 2) begin n_bad++; $display("FAIL flush_credits got %0d accepts want 2", sb3.size()); end
        cyc(0, 0, 1, BASE, 0, 0, 0, 0);
        n_cmp++;
        if (rdy3 !== 1'b0) begin n_bad++; $display("FAIL flush_full got ready=%b want 0", rdy3); end
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, BASE, 1, 0, 0, 0);
            if (fire3) begin
                n_cmp++;
                if (sb3.size() == 0) begin
                    n_bad++; $display("FAIL flush_extra got data=%h want no response", dat3);
                end else begin
                    e = sb3.pop_front();
                    if ({err3, dat3} !== {e.err, e.data} || dat3 !== ((r == 0) ? 32'h0010_0093 : 32'hDEAD_BEEF)) begin
                        n_bad++; $display("FAIL flush_ram%0d got err=%b data=%h want err=%b data=%h", r, err3, dat3, e.err, e.data);
                    end
                end
                r++;
            end
        end
        n_cmp++;
        if (r !== 2) begin n_bad++; $display("FAIL flush_count got %0d want 2", r); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_err();
        test_rbw();
        test_latency3();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sodor_imem_responder.md
Name: sodor_imem_responder

Overview:
- Synthesizable instruction-memory responder: the slave end of the core's imem request/response interface.
- Accepts fetch requests (address), reads a word-addressed text RAM after a configurable latency, and returns data through a small response buffer with backpressure.
- Includes a preload write port so benches and boot logic can fill the text image before or while reset is held.
- Sits beside SodorInternalTile's core and replaces the behavioural text memory.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, instruction word width
- DEPTH_WORDS, 1024, RAM depth in words (power of two)
- BASE_ADDR, 32'h80000000, byte address of word 0
- LATENCY, 1, request-accept to response-valid cycles (legal 1..4)
- RESP_DEPTH, 2, maximum outstanding requests and response buffer entries (legal 1..4)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- io_imem_req_valid  in  1  fetch request valid
- io_imem_req_ready  out  1  responder can accept a request
- io_imem_req_bits_addr  in  ADDR_W  byte address
- io_imem_resp_valid  out  1  response valid
- io_imem_resp_ready  in  1  core accepts response
- io_imem_resp_bits_data  out  DATA_W  instruction word
- io_imem_resp_bits_err  out  1  misaligned or out-of-range request
- io_load_valid  in  1  preload write strobe
- io_load_idx  in  clog2(DEPTH_WORDS)  word index
- io_load_data  in  DATA_W  word to write

Behaviour:
- Reset:
  - Outputs: req_ready=0 during reset, 1 in the first cycle after; resp_valid=0, resp data=0, err=0.
  - Pipeline and buffer flushed; outstanding=0.
  - RAM contents are not cleared. A reset asserted mid-operation drops all in-flight responses silently.
- Handshakes:
  - Request accepted on req_valid && req_ready.
  - Response consumed on resp_valid && resp_ready.
  - resp_valid, data and err hold stable until consumed.
- Credit rule:
  - outstanding = accepted requests not yet consumed.
  - req_ready = (outstanding < RESP_DEPTH) || (outstanding==RESP_DEPTH && resp consumed this cycle).
  - Simultaneous accept and consume leaves outstanding unchanged.
- Address check:
  - offset = addr - BASE_ADDR, computed modulo 2^ADDR_W.
  - err = addr[1:0]!=0 || offset >= DEPTH_WORDS*4.
  - On err: data=0 and the RAM is not read.
  - Otherwise the word index is offset[clog2(DEPTH_WORDS)+1:2].
- Latency:
  - Accepted request travels a LATENCY-stage valid/data/err pipeline; the RAM read occurs in stage 1.
  - Pipeline exit writes the response buffer, which has a bypass: if the buffer is empty and resp_ready=1, the exit entry is presented the same cycle.
  - Net result with resp_ready held high: response valid exactly LATENCY cycles after accept, and one response per cycle sustained.
- Ordering: responses are returned strictly in request order.
- Preload:
  - Write occurs on any cycle, including during reset.
  - Load and fetch read of the same word in the same cycle: the fetch returns the OLD data (read-before-write).
- Buffer overflow cannot occur by construction. Assertion required: buffer write while full is an error.
- Wrap-around: address 0xFFFFFFFC with the default BASE_ADDR is out of range and returns err=1.

Decomposition:
- Package sodor_imem_pkg: BASE_ADDR default, LATENCY/RESP_DEPTH legal bounds, a function computing the word index and err from addr, and the response struct (data, err).
- One sub-module: sodor_imem_resp_fifo, a RESP_DEPTH-entry synchronous FIFO with bypass, exposing count, full and empty.

Test Plan:
- Preload words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0xFFDFF06F; release reset; request 0x80000000..0x8000000C back-to-back with resp_ready=1 and LATENCY=1 -> responses on consecutive cycles starting 1 cycle after the first accept, data in order, err=0.
- Backpressure, RESP_DEPTH=2: hold resp_ready=0 and issue 3 requests -> req_ready drops after 2 accepts and resp data holds word 0. Raise resp_ready for 1 cycle -> word 0 consumed, third request accepted in the same cycle.
- Request 0x80000002 and 0x80001000 (DEPTH_WORDS=1024) -> err=1, data=0 for both; the following request to 0x80000004 returns 0x00100093, err=0.
- Same-cycle load of idx 5 = 0xDEADBEEF with fetch of 0x80000014 (old value 0x00000013) -> fetch returns 0x00000013; the next fetch of the same address returns 0xDEADBEEF.
- LATENCY=3: single request -> resp_valid exactly 3 cycles after accept. Then reset asserted with 2 requests in flight -> no response emerges, outstanding=0, req_ready=1 the cycle after reset deasserts, and RAM contents are intact.
